// File: rtl/calc_pkg.sv
// Shared types and limits for the calculator datapath: operator codes,
// operand-builder states and the accepted operand magnitude.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_NEG  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    ENTRY_A = 2'd0,
    ENTRY_B = 2'd1,
    ISSUE   = 2'd2
  } builder_state_t;

  localparam int OPERAND_MAG_MAX = 32767;

  // Two's-complement value of a sign/magnitude entry.
  function automatic logic [15:0] apply_sign(input logic [15:0] mag, input logic neg);
    return neg ? (~mag + 16'd1) : mag;
  endfunction

endpackage

// File: rtl/digit_accumulator.sv
// Combinational decimal shift-in: mag*10+digit with limit check.
// Overflow handling selected by OPERAND_SATURATE_EN (saturate) or hold (default).
module digit_accumulator
  import calc_pkg::*;
#(
  parameter int MAX_MAG = OPERAND_MAG_MAX
) (
  input  logic [15:0] mag,
  input  logic [3:0]  digit,
  output logic [15:0] next_mag,
  output logic        ovf
);

  logic [19:0] sum;

  // 20 bits holds 65535*10+9 without wrap, so the compare is exact.
  assign sum = ({4'd0, mag} * 20'd10) + {16'd0, digit};
  assign ovf = (sum > 20'(MAX_MAG));

`ifdef OPERAND_SATURATE_EN
  assign next_mag = ovf ? 16'(MAX_MAG) : sum[15:0];
`else
  assign next_mag = ovf ? mag : sum[15:0];
`endif

endmodule

// File: rtl/operand_builder.sv
// Builds signed A/B operands from decoded keys and issues an A-op-B request.
// Overflow behaviour of digit entry depends on OPERAND_SATURATE_EN.
//
// Handshakes: upstream key is consumed once per read_input assertion
// (read_input must drop for a cycle to re-arm), acknowledged by a one-cycle
// key_read. Downstream request completes in the cycle calc_valid && calc_ready;
// calc_valid holds with stable operands/op_code until then.
module operand_builder
  import calc_pkg::*;
#(
  parameter int MAX_MAG = OPERAND_MAG_MAX
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        read_input,
  input  logic [3:0]  keypad_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        key_read,
  output logic [15:0] display_value,
  output logic [15:0] operand_a,
  output logic [15:0] operand_b,
  output logic [2:0]  op_code,
  output logic        calc_valid,
  input  logic        calc_ready,
  output logic        entry_ovf,
  output logic [1:0]  dbg_state
);

  builder_state_t state;
  op_t            op_q;
  logic [15:0]    mag;
  logic           neg;
  logic           have_digit;
  logic           armed;

  logic           consume;
  logic [15:0]    entry;
  logic [15:0]    acc_mag;
  logic           acc_ovf;

  digit_accumulator #(.MAX_MAG(MAX_MAG)) u_acc (
    .mag      (mag),
    .digit    (keypad_input),
    .next_mag (acc_mag),
    .ovf      (acc_ovf)
  );

  assign consume       = read_input && armed && (state != ISSUE);
  assign entry         = apply_sign(mag, neg);
  assign display_value = (state == ISSUE) ? operand_b : entry;
  assign op_code       = op_q;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= ENTRY_A;
      op_q       <= OP_NONE;
      mag        <= 16'd0;
      neg        <= 1'b0;
      have_digit <= 1'b0;
      armed      <= 1'b0;
      operand_a  <= 16'd0;
      operand_b  <= 16'd0;
      key_read   <= 1'b0;
      calc_valid <= 1'b0;
      entry_ovf  <= 1'b0;
    end else begin
      key_read <= consume;
      if (consume)
        armed <= 1'b0;
      else if (!read_input)
        armed <= 1'b1;

      case (state)
        ENTRY_A, ENTRY_B: begin
          if (consume) begin
            if (equal_input) begin
              if (state == ENTRY_B) begin
                operand_b  <= entry;
                calc_valid <= 1'b1;
                state      <= ISSUE;
              end
            end else if (operator_input != 3'b000) begin
              case (op_t'(operator_input))
                OP_NEG: neg <= ~neg;
                OP_ADD, OP_SUB, OP_MUL: begin
                  if (state == ENTRY_A) begin
                    operand_a  <= entry;
                    op_q       <= op_t'(operator_input);
                    mag        <= 16'd0;
                    neg        <= 1'b0;
                    have_digit <= 1'b0;
                    state      <= ENTRY_B;
                  end else if (!have_digit) begin
                    op_q <= op_t'(operator_input);
                  end
                end
                default: ;
              endcase
            end else if (keypad_input <= 4'd9) begin
              mag <= acc_mag;
              if (acc_ovf)
                entry_ovf <= 1'b1;
              else
                have_digit <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (calc_ready) begin
            calc_valid <= 1'b0;
            mag        <= 16'd0;
            neg        <= 1'b0;
            have_digit <= 1'b0;
            entry_ovf  <= 1'b0;
            op_q       <= OP_NONE;
            state      <= ENTRY_A;
          end
        end
        default: state <= ENTRY_A;
      endcase
    end
  end

endmodule
